// File: rtl/slow_peripheral_responder_pkg.sv
// Shared constants, FSM state type and address-decode helper for the
// slow peripheral responder.
package slow_peripheral_pkg;

   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;

   localparam logic [DATA_W-1:0] ID_VALUE = 32'h5150_0001;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } wait_state_e;

   // True when the word address falls inside the 16-word register map.
   function automatic logic is_reg_word(input logic [ADDR_W-1:0] addr);
      return (addr < ADDR_W'(NUM_REGS));
   endfunction

endpackage

// File: rtl/slow_peripheral_responder_if.sv
// Memory-mapped slave bus between a master and the slow peripheral.
interface slow_peripheral_responder_if;
   import slow_peripheral_pkg::*;

   logic [ADDR_W-1:0] slave_address;
   logic [3:0]        slave_byteenable;
   logic              slave_read;
   logic              slave_write;
   logic [DATA_W-1:0] slave_writedata;
   logic              slave_waitrequest;
   logic [DATA_W-1:0] slave_readdata;
   logic              slave_readdatavalid;
   logic              slave_endofpacket;

   modport master (
      output slave_address, slave_byteenable, slave_read, slave_write, slave_writedata,
      input  slave_waitrequest, slave_readdata, slave_readdatavalid, slave_endofpacket
   );

   modport slave (
      input  slave_address, slave_byteenable, slave_read, slave_write, slave_writedata,
      output slave_waitrequest, slave_readdata, slave_readdatavalid, slave_endofpacket
   );

endinterface

// File: rtl/slow_peripheral_responder_rdpipe.sv
// Fixed-latency read response pipeline: valid/data/eop shift DEPTH stages.
// Data and eop are stored as zero in empty stages so the outputs are zero
// whenever valid is low; the clear also masks the outputs combinationally.
module slow_peripheral_responder_rdpipe
   import slow_peripheral_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              clr_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_eop_i,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_eop_o
);

   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  eop_q;
   logic [DATA_W-1:0] data_q [DEPTH];

   // Shift every stage by one per cycle; clear drops all in-flight responses.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         valid_q <= '0;
         eop_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= in_valid_i;
         eop_q[0]   <= in_valid_i & in_eop_i;
         data_q[0]  <= in_valid_i ? in_data_i : '0;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            eop_q[i]   <= eop_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign out_valid_o = valid_q[DEPTH-1] & ~clr_i;
   assign out_eop_o   = eop_q[DEPTH-1] & ~clr_i;
   assign out_data_o  = clr_i ? '0 : data_q[DEPTH-1];

endmodule

// File: rtl/slow_peripheral_responder.sv
// Slow register-file peripheral: inserts WAIT_STATES stall cycles per
// transfer, returns reads READ_LATENCY cycles after acceptance.
module slow_peripheral_responder
   import slow_peripheral_pkg::*;
#(
   parameter int WAIT_STATES  = 1,
   parameter int READ_LATENCY = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   slow_peripheral_responder_if.slave  bus
);

   localparam logic [3:0] WAIT_LIM = WAIT_STATES[3:0];

   wait_state_e       state_q, state_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [15:0]       wr_cnt_q;
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic              req;
   logic              accept;
   logic              wr_acc;
   logic              rd_acc;
   logic              mapped;
   logic [3:0]        word_idx;
   logic [DATA_W-1:0] rd_data;
   logic              rd_eop;

   assign req      = bus.slave_read | bus.slave_write;
   assign mapped   = is_reg_word(bus.slave_address);
   assign word_idx = bus.slave_address[3:0];

   // Stall is purely combinational; reset holds any present request off.
   generate
      if (WAIT_STATES == 0) begin : g_no_wait
         assign bus.slave_waitrequest = 1'b0;
      end else begin : g_wait
         assign bus.slave_waitrequest = req & (reset | (wait_cnt_q != WAIT_LIM));
      end
   endgenerate

   // Nothing is accepted while reset is high, even with zero wait states.
   assign accept = req & ~bus.slave_waitrequest & ~reset;
   // A simultaneous read+write is a write only.
   assign wr_acc = accept & bus.slave_write;
   assign rd_acc = accept & bus.slave_read & ~bus.slave_write;

   // Wait FSM next state: count stall cycles, restart on accept or request drop.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_IDLE, ST_STALL: begin
            if (accept) begin
               state_d    = ST_IDLE;
               wait_cnt_d = 4'd0;
            end else if (req) begin
               state_d    = ST_STALL;
               wait_cnt_d = wait_cnt_q + 4'd1;
            end else begin
               state_d    = ST_IDLE;
               wait_cnt_d = 4'd0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            wait_cnt_d = 4'd0;
         end
      endcase
   end

   // Wait FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Register file: only words 2..15 are writable, per enabled byte lane.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_acc && mapped && (word_idx >= 4'd2)) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.slave_byteenable[b]) begin
               regs_q[word_idx][b*8 +: 8] <= bus.slave_writedata[b*8 +: 8];
            end
         end
      end
   end

   // Accepted-write counter, any address, wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_cnt_q <= 16'd0;
      end else if (wr_acc) begin
         wr_cnt_q <= wr_cnt_q + 16'd1;
      end
   end

   // Read decode sampled at acceptance; unmapped words read as zero.
   always_comb begin
      rd_data = '0;
      rd_eop  = 1'b0;
      if (mapped) begin
         case (word_idx)
            4'd0:    rd_data = ID_VALUE;
            4'd1:    rd_data = {16'h0000, wr_cnt_q};
            default: rd_data = regs_q[word_idx];
         endcase
         rd_eop = (word_idx == 4'd15);
      end
   end

   slow_peripheral_responder_rdpipe #(
      .DEPTH (READ_LATENCY)
   ) u_rdpipe (
      .clk         (clk),
      .clr_i       (reset),
      .in_valid_i  (rd_acc),
      .in_data_i   (rd_data),
      .in_eop_i    (rd_eop),
      .out_valid_o (bus.slave_readdatavalid),
      .out_data_o  (bus.slave_readdata),
      .out_eop_o   (bus.slave_endofpacket)
   );

endmodule

// File: tb/tb_slow_peripheral_responder.sv
// Directed bench: dut1 uses defaults (1 wait state, latency 2),
// dut2 uses no wait states and latency 3.
module tb_slow_peripheral_responder;
   import slow_peripheral_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset1;
   logic reset2;

   slow_peripheral_responder_if bus1 ();
   slow_peripheral_responder_if bus2 ();

   slow_peripheral_responder #(.WAIT_STATES(1), .READ_LATENCY(2)) dut1 (
      .clk (clk), .reset (reset1), .bus (bus1)
   );
   slow_peripheral_responder #(.WAIT_STATES(0), .READ_LATENCY(3)) dut2 (
      .clk (clk), .reset (reset2), .bus (bus2)
   );

   int total  = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic drive(input bit sel, input logic rd, input logic wr, input logic [11:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
      if (sel) begin
         bus2.slave_read = rd; bus2.slave_write = wr; bus2.slave_address = addr;
         bus2.slave_byteenable = be; bus2.slave_writedata = data;
      end else begin
         bus1.slave_read = rd; bus1.slave_write = wr; bus1.slave_address = addr;
         bus1.slave_byteenable = be; bus1.slave_writedata = data;
      end
   endtask

   function automatic logic wreq(input bit sel);
      return sel ? bus2.slave_waitrequest : bus1.slave_waitrequest;
   endfunction
   function automatic logic rvalid(input bit sel);
      return sel ? bus2.slave_readdatavalid : bus1.slave_readdatavalid;
   endfunction
   function automatic logic [31:0] rdata(input bit sel);
      return sel ? bus2.slave_readdata : bus1.slave_readdata;
   endfunction
   function automatic logic reop(input bit sel);
      return sel ? bus2.slave_endofpacket : bus1.slave_endofpacket;
   endfunction

   // Count stall cycles until acceptance, pass the accept edge, release the bus.
   task automatic wait_accept(input bit sel, output int stalls);
      stalls = 0;
      while (wreq(sel) && stalls < 20) begin
         @(posedge clk); #1;
         stalls++;
      end
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
   endtask

   task automatic xfer(input bit sel, input logic rd, input logic wr, input logic [11:0] addr,
                       input logic [3:0] be, input logic [31:0] data, output int stalls);
      drive(sel, rd, wr, addr, be, data);
      #1;
      wait_accept(sel, stalls);
   endtask

   // Called one step after the accept edge: lat counts cycles to the response.
   task automatic get_resp(input bit sel, output logic [31:0] data, output logic eop,
                           output int lat, output logic extra);
      lat = 1;
      while (!rvalid(sel) && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      data = rdata(sel);
      eop  = reop(sel);
      @(posedge clk); #1;
      extra = rvalid(sel);
   endtask

   task automatic rd(input bit sel, input logic [11:0] addr, output logic [31:0] data,
                     output logic eop, output int stalls, output int lat, output logic extra);
      xfer(sel, 1'b1, 1'b0, addr, 4'h0, 32'h0, stalls);
      get_resp(sel, data, eop, lat, extra);
   endtask

   task automatic count_valids(input bit sel, input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (rvalid(sel)) cnt++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      logic        x;
      int          s;
      int          l;
      int          c;

      reset1 = 1'b1;
      reset2 = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_waitreq_idle", {31'b0, bus1.slave_waitrequest}, 32'h0);
      check("rst_valid", {31'b0, bus1.slave_readdatavalid}, 32'h0);
      check("rst_readdata", bus1.slave_readdata, 32'h0);
      check("rst_eop", {31'b0, bus1.slave_endofpacket}, 32'h0);
      check("rst_valid_dut2", {31'b0, bus2.slave_readdatavalid}, 32'h0);

      // Request present during reset, held across deassertion
      drive(1'b0, 1'b1, 1'b0, 12'd0, 4'h0, 32'h0);
      #1;
      check("rst_waitreq_req", {31'b0, bus1.slave_waitrequest}, 32'h1);
      @(posedge clk); #1;
      reset1 = 1'b0;
      reset2 = 1'b0;
      #1;
      wait_accept(1'b0, s);
      check("post_rst_stalls", s, 32'd1);
      get_resp(1'b0, d, e, l, x);
      check("post_rst_id", d, ID_VALUE);
      check("post_rst_lat", l, 32'd2);

      // Basic write then read of word 5
      xfer(1'b0, 1'b0, 1'b1, 12'd5, 4'hF, 32'hA5A5_1234, s);
      check("wr5_stalls", s, 32'd1);
      rd(1'b0, 12'd5, d, e, s, l, x);
      check("rd5_stalls", s, 32'd1);
      check("rd5_lat", l, 32'd2);
      check("rd5_data", d, 32'hA5A5_1234);
      check("rd5_eop", {31'b0, e}, 32'h0);
      check("rd5_one_cycle", {31'b0, x}, 32'h0);

      // Partial byte enables on word 3, then write counter
      xfer(1'b0, 1'b0, 1'b1, 12'd3, 4'h5, 32'hFFFF_FFFF, s);
      rd(1'b0, 12'd3, d, e, s, l, x);
      check("rd3_byteen", d, 32'h00FF_00FF);
      rd(1'b0, 12'd1, d, e, s, l, x);
      check("wrcnt_2", d, 32'h0000_0002);

      // Word 15 carries end-of-packet
      rd(1'b0, 12'd15, d, e, s, l, x);
      check("rd15_data", d, 32'h0);
      check("rd15_eop", {31'b0, e}, 32'h1);

      // Writes to the ID word are ignored for data but still counted
      xfer(1'b0, 1'b0, 1'b1, 12'd0, 4'hF, 32'hFFFF_FFFF, s);
      rd(1'b0, 12'd0, d, e, s, l, x);
      check("id_ro", d, ID_VALUE);

      // Request held across an accept becomes a new stalled transfer
      drive(1'b0, 1'b0, 1'b1, 12'd2, 4'hF, 32'h0000_0011);
      #1;
      check("held_stall1", {31'b0, bus1.slave_waitrequest}, 32'h1);
      @(posedge clk); #1;
      check("held_accept1", {31'b0, bus1.slave_waitrequest}, 32'h0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 12'd2, 4'h2, 32'h0000_2200);
      #1;
      check("held_stall2", {31'b0, bus1.slave_waitrequest}, 32'h1);
      @(posedge clk); #1;
      check("held_accept2", {31'b0, bus1.slave_waitrequest}, 32'h0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);

      // Request dropped during a stall restarts the count
      drive(1'b0, 1'b1, 1'b0, 12'd2, 4'h0, 32'h0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 12'd2, 4'h0, 32'h0);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 12'd2, 4'h0, 32'h0);
      #1;
      check("drop_restall", {31'b0, bus1.slave_waitrequest}, 32'h1);
      wait_accept(1'b0, s);
      get_resp(1'b0, d, e, l, x);
      check("rd2_held_writes", d, 32'h0000_2211);

      // Read+write together is a write only
      xfer(1'b0, 1'b1, 1'b1, 12'd4, 4'hF, 32'h0000_0001, s);
      count_valids(1'b0, 5, c);
      check("rdwr_no_resp", c, 32'd0);
      rd(1'b0, 12'd4, d, e, s, l, x);
      check("rd4_data", d, 32'h0000_0001);
      rd(1'b0, 12'd1, d, e, s, l, x);
      check("wrcnt_6", d, 32'h0000_0006);

      // Reset with a read in flight drops it and clears state
      xfer(1'b0, 1'b1, 1'b0, 12'd2, 4'h0, 32'h0, s);
      reset1 = 1'b1;
      @(posedge clk); #1;
      reset1 = 1'b0;
      count_valids(1'b0, 6, c);
      check("rst_drop_dut1", c, 32'd0);
      rd(1'b0, 12'd2, d, e, s, l, x);
      check("rst_word2", d, 32'h0);
      rd(1'b0, 12'd0, d, e, s, l, x);
      check("rst_id", d, ID_VALUE);
      rd(1'b0, 12'd1, d, e, s, l, x);
      check("rst_wrcnt", d, 32'h0);

      // dut2: write counter wrap after 65536 writes to an unmapped word
      drive(1'b1, 1'b0, 1'b1, 12'h800, 4'hF, 32'hFFFF_FFFF);
      #1;
      check("ws0_no_wait", {31'b0, bus2.slave_waitrequest}, 32'h0);
      repeat (65535) @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      rd(1'b1, 12'd1, d, e, s, l, x);
      check("wrcnt_ffff", d, 32'h0000_FFFF);
      check("dut2_lat", l, 32'd3);
      check("dut2_stalls", s, 32'd0);
      xfer(1'b1, 1'b0, 1'b1, 12'h800, 4'hF, 32'h0, s);
      rd(1'b1, 12'd1, d, e, s, l, x);
      check("wrcnt_wrap", d, 32'h0);

      // Read the cycle after a write to the same word sees the new data
      drive(1'b1, 1'b0, 1'b1, 12'd7, 4'hF, 32'h0BAD_F00D);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b0, 12'd7, 4'h0, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      get_resp(1'b1, d, e, l, x);
      check("raw_data", d, 32'h0BAD_F00D);
      check("raw_lat", l, 32'd3);

      // Back-to-back pipelined reads of words 0, 15, 100
      xfer(1'b1, 1'b0, 1'b1, 12'd15, 4'hF, 32'hCAFE_0015, s);
      drive(1'b1, 1'b1, 1'b0, 12'd0, 4'h0, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b0, 12'd15, 4'h0, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b0, 12'd100, 4'h0, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      check("pipe0_valid", {31'b0, bus2.slave_readdatavalid}, 32'h1);
      check("pipe0_data", bus2.slave_readdata, ID_VALUE);
      check("pipe0_eop", {31'b0, bus2.slave_endofpacket}, 32'h0);
      @(posedge clk); #1;
      check("pipe1_valid", {31'b0, bus2.slave_readdatavalid}, 32'h1);
      check("pipe1_data", bus2.slave_readdata, 32'hCAFE_0015);
      check("pipe1_eop", {31'b0, bus2.slave_endofpacket}, 32'h1);
      @(posedge clk); #1;
      check("pipe2_valid", {31'b0, bus2.slave_readdatavalid}, 32'h1);
      check("pipe2_data", bus2.slave_readdata, 32'h0);
      check("pipe2_eop", {31'b0, bus2.slave_endofpacket}, 32'h0);
      @(posedge clk); #1;
      check("pipe_end_valid", {31'b0, bus2.slave_readdatavalid}, 32'h0);
      check("pipe_end_data", bus2.slave_readdata, 32'h0);

      // dut2: reset with two reads in flight
      xfer(1'b1, 1'b0, 1'b1, 12'd2, 4'hF, 32'h1234_5678, s);
      drive(1'b1, 1'b1, 1'b0, 12'd2, 4'h0, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b0, 12'd0, 4'h0, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      reset2 = 1'b1;
      @(posedge clk); #1;
      reset2 = 1'b0;
      count_valids(1'b1, 8, c);
      check("rst_drop_dut2", c, 32'd0);
      rd(1'b1, 12'd2, d, e, s, l, x);
      check("rst2_word2", d, 32'h0);
      rd(1'b1, 12'd0, d, e, s, l, x);
      check("rst2_id", d, ID_VALUE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/slow_peripheral_responder.md
SLOW_PERIPHERAL_RESPONDER -- requirements
Module: slow_peripheral_responder

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1: waitrequest cycles inserted before each transfer is accepted (0..15).
REQ-002 The block SHALL have parameter READ_LATENCY, default 2: cycles from read acceptance to readdatavalid (1..8).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port slave_address, input, 12 bits: word address.
REQ-006 The block SHALL have port slave_byteenable, input, 4 bits: write byte lanes.
REQ-007 The block SHALL have ports slave_read and slave_write, input, 1 bit each: transfer requests.
REQ-008 The block SHALL have port slave_writedata, input, 32 bits: write data.
REQ-009 The block SHALL have port slave_waitrequest, output, 1 bit: stall; combinational from request and state.
REQ-010 The block SHALL have port slave_readdata, output, 32 bits: read response data.
REQ-011 The block SHALL have port slave_readdatavalid, output, 1 bit: read response strobe.
REQ-012 The block SHALL have port slave_endofpacket, output, 1 bit: qualifies the read response, valid with readdatavalid.

Function
REQ-013 The register map SHALL be: word 0 = read-only ID 0x5150_0001; word 1 = read-only 16-bit accepted-write counter, zero-extended; words 2..15 = R/W; words 16..4095 unmapped.
REQ-014 A transfer SHALL be accepted in the cycle where (slave_read|slave_write)=1 and slave_waitrequest=0.
REQ-015 The wait FSM SHALL have two states: IDLE and STALL. A 4-bit wait_cnt SHALL count stall cycles.
REQ-016 slave_waitrequest SHALL equal (slave_read|slave_write) & (wait_cnt != WAIT_STATES). With WAIT_STATES=0 it SHALL be constantly 0.
REQ-017 FSM transitions: IDLE->STALL on request with WAIT_STATES>0, with wait_cnt incrementing; STALL increments wait_cnt each cycle; on acceptance, wait_cnt SHALL clear to 0 and the FSM SHALL return to IDLE.
REQ-018 If the request drops while in STALL, the FSM SHALL return to IDLE and clear wait_cnt.
REQ-019 After an acceptance, a request held high on the next cycle SHALL be a new transfer and SHALL incur a full WAIT_STATES stall.
REQ-020 Writes SHALL update only the enabled byte lanes of words 2..15 at the acceptance edge.
REQ-021 Writes to words 0, 1 and to unmapped words SHALL be ignored for data.
REQ-022 Every accepted write SHALL increment the write counter, wrapping 0xFFFF->0x0000.
REQ-023 An accepted read SHALL sample the register value at acceptance and SHALL assert slave_readdatavalid for exactly one cycle, READ_LATENCY cycles later.
REQ-024 Unmapped reads SHALL return 0x0000_0000.
REQ-025 slave_endofpacket SHALL be 1 with the response to a word-15 read, and 0 otherwise.
REQ-026 Reads SHALL be fully pipelined: up to READ_LATENCY responses in flight, returned in acceptance order, with no backpressure.
REQ-027 If read and write are asserted together, the transfer SHALL be treated as a write only, with no read response.
REQ-028 A read accepted the cycle after a write to the same word SHALL return the new data.
REQ-029 slave_readdata and slave_endofpacket SHALL be 0 whenever slave_readdatavalid=0.

Reset
REQ-030 Reset SHALL force: FSM=IDLE, wait_cnt=0, write counter=0, words 2..15=0, all in-flight responses dropped.
REQ-031 During reset, slave_readdatavalid=0, slave_readdata=0, slave_endofpacket=0, and slave_waitrequest=1 if a request is present, else 0.
REQ-032 A request held across reset deassertion SHALL start a fresh WAIT_STATES count on the first cycle after reset.

Structure
REQ-033 Package slow_peripheral_pkg SHALL hold: ID constant 0x5150_0001, NUM_REGS=16, ADDR_W=12, DATA_W=32, and the FSM state enum.
REQ-034 Sub-module slow_peripheral_responder_rdpipe SHALL implement the READ_LATENCY-deep valid/data/eop shift pipeline with synchronous clear.

Verification
REQ-035 Defaults: write 0xA5A5_1234 to word 5 with byteenable 0xF -> waitrequest high 1 cycle, accept next cycle; then read word 5 -> readdatavalid exactly 2 cycles after acceptance with data 0xA5A5_1234.
REQ-036 Write 0xFFFF_FFFF to word 3 with byteenable 0x5 over prior 0 -> read word 3 returns 0x00FF_00FF; a following read of word 1 returns 0x0000_0002.
REQ-037 WAIT_STATES=0, READ_LATENCY=3: back-to-back reads of words 0, 15, 100 -> three consecutive readdatavalid cycles returning 0x5150_0001 (eop 0), word15 (eop 1), 0 (eop 0).
REQ-038 Preload write counter to 0xFFFF via 65535 writes, then one more write -> read word 1 returns 0x0000_0000.
REQ-039 Assert reset for 1 cycle while two reads are in flight -> no readdatavalid afterward; word 2 reads back 0; ID still reads 0x5150_0001.
REQ-040 Read and write asserted together to word 4 with data 0x1 -> no readdatavalid; subsequent read of word 4 returns 0x0000_0001.
